// File: rtl/upe_var_accum.sv
// upe_var_accum: sums NTERMS 32-bit products per group into an ACC_W-bit total with a sticky overflow flag.
// Define UPE_ACC_SAT_EN to saturate the total on carry instead of wrapping.
module upe_var_accum #(
  parameter int NTERMS = 4,
  parameter int ACC_W  = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  typedef enum logic {ACCUM, DONE} state_t;
  localparam logic [15:0] LAST = 16'(NTERMS - 1);
  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_xfer;
  assign w_xfer = in_valid & r_in_ready;
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W-31){1'b0}}, in_prod};
`ifdef UPE_ACC_SAT_EN
  assign w_acc_nxt = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == ACCUM) begin
      r_in_ready <= 1'b1;
      if (w_xfer) begin
        r_acc <= w_acc_nxt;
        r_ovf <= r_ovf | w_sum[ACC_W];
        if (r_cnt == LAST) begin
          r_cnt       <= '0;
          r_state     <= DONE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end else if (out_ready) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end
  end
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
endmodule
